stream_arbiter_n: RTL and testbench
===================================

// Module: stream_arbiter_n
// PURPOSE
//   N-input round-robin merger for 32-bit stb/ack streams. Generalises the fixed
//   two-input arbiter that merges the application and server rs232_tx streams.
//   Optional packet-lock mode holds the grant until a terminator word, so messages
//   from different sources never interleave. A lock timeout raises a sticky
//   exception, which the top level ORs into the design exception.
// PARAMETERS
//   N          2           number of input streams (1..16)
//   WIDTH      32          data width of every stream
//   LOCK_MODE  0           0 = re-arbitrate per word; 1 = hold grant until terminator
//   TERM_MASK  32'h000000FF  bits compared when detecting the terminator
//   TERM_VALUE 32'h00000000  word is a terminator iff (word & TERM_MASK) == TERM_VALUE
//   TIMEOUT    1024        cycles a locked input may leave stb low before lock is dropped
// PORTS
//   clk             in   1        clock; all logic on rising edge
//   rst             in   1        synchronous reset, active-low (rst==0 resets)
//   exception       out  1        sticky lock-timeout flag
//   input_in        in   N*WIDTH  input i occupies bits [i*WIDTH +: WIDTH]
//   input_in_stb    in   N        input i has a word
//   input_in_ack    out  N        input i word taken (at most one bit set)
//   output_out      out  WIDTH    merged data (registered)
//   output_out_stb  out  1        output word valid
//   output_out_ack  in   1        sink accepts output word
// BEHAVIOUR
//   Transfer rule: a word moves only in a cycle where stb and ack are both high.
//   A source holds stb and data stable until acked.
//   Reset: state=ARB, input_in_ack=0, output_out_stb=0, output_out=0, exception=0,
//     lock=0, tcount=0, last=N-1 (so input 0 has first priority).
//   States:
//     ARB: if any stb, grant <= first i with stb[i], scanning from last+1 modulo N
//       -> ACK. No stb: stay in ARB.
//     ACK: input_in_ack[grant]=1 (registered, no combinational stb->ack path).
//       stb[grant]=1: latch data into output_out; lock <= LOCK_MODE &&
//         !terminator(data); tcount <= 0 -> OUT.
//       stb[grant]=0 and !lock: -> ARB with last unchanged.
//       stb[grant]=0 and lock: tcount++. When tcount==TIMEOUT-1: lock <= 0,
//         exception <= 1, last <= grant -> ARB.
//     OUT: output_out_stb=1, data stable. On output_out_ack: stb drops next cycle.
//       If lock: -> ACK with same grant. Else: last <= grant -> ARB.
//   Latency: stb rises in ARB at cycle t -> ack at t+1 -> output_out_stb at t+2.
//   Throughput (zero-wait sink): 3 cycles/word unlocked; 2 cycles/word while locked.
//   Fairness: with all N requesting in LOCK_MODE=0, grants cycle 0,1,..,N-1,0.
//     No input waits more than N-1 other words.
//   Simultaneous requests: resolved only in ARB. Requests arriving during ACK/OUT
//     wait for the next ARB.
//   Locked input: other inputs never acked until terminator word forwarded or timeout.
//   Terminator check uses the latched word. A terminator as the first word of a
//     grant never sets lock.
//   N==1: grant always 0; rotation degenerates; lock/timeout still apply.
//   exception: set only by timeout; cleared only by reset. Arbitration continues.
//   Reset mid-operation: any held word is discarded and no ack is issued in the
//     reset cycle. Upstream must resend.
//   Widths: grant/last use $clog2(N) bits (min 1). tcount uses $clog2(TIMEOUT)+1 bits.
// TESTING
//   1 N=2,LOCK=0: both stb high with words 0xA0,0xB0 -> out 0xA0,0xB0; next pair
//     0xA1,0xB1 -> out 0xA1 then 0xB1.
//   2 N=4,LOCK=0: all stb high, 8 words each -> output source order 0,1,2,3 repeated.
//     Per-input order preserved. No word lost or duplicated.
//   3 LOCK=1: in0 sends 0x41,0x42,0x00 while in1 requests -> out 0x41,0x42,0x00
//     before any in1 word.
//   4 LOCK=1,TIMEOUT=16: in0 sends 0x41 then drops stb -> after 16 cycles exception=1.
//     in1 word forwarded next. exception remains 1.
//   5 Sink holds output_out_ack low 20 cycles -> output_out and output_out_stb stable.
//     No input acked. Resumes on ack.
//   6 rst low during OUT with word held -> cycle after: all acks 0, out_stb 0,
//     exception 0. Next grant goes to input 0.

Source files
------------

// File: rtl/stream_arbiter_n.sv
// stream_arbiter_n: N-input round-robin merger for stb/ack word streams.
// The optional packet-lock mode keeps the grant on one source until a
// terminator word has been forwarded. If a locked source goes quiet for
// TIMEOUT cycles, the lock is released and a sticky exception is raised.
module stream_arbiter_n #(
  parameter int                N          = 2,
  parameter int                WIDTH      = 32,
  parameter int                LOCK_MODE  = 0,
  parameter logic [WIDTH-1:0]  TERM_MASK  = 'hFF,
  parameter logic [WIDTH-1:0]  TERM_VALUE = '0,
  parameter int                TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  output logic               exception,
  input  logic [N*WIDTH-1:0] input_in,
  input  logic [N-1:0]       input_in_stb,
  output logic [N-1:0]       input_in_ack,
  output logic [WIDTH-1:0]   output_out,
  output logic               output_out_stb,
  input  logic               output_out_ack
);

  localparam int            GW       = (N > 1) ? $clog2(N) : 1;
  localparam int            TW       = $clog2(TIMEOUT) + 1;
  localparam logic [GW-1:0] LAST_RST = GW'(N - 1);
  localparam logic [TW-1:0] TC_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ARB, ACK, OUT} state_t;

  state_t           state, state_nxt;
  logic [GW-1:0]    grant, grant_nxt;
  logic [GW-1:0]    last, last_nxt;
  logic [GW-1:0]    pick, idx;
  logic             pick_vld;
  logic             lock, lock_nxt;
  logic             exc_nxt;
  logic [TW-1:0]    tcount, tcount_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] sel_data;
  logic             sel_stb;

  // A word ends a packet when its masked bits equal the terminator value.
  function automatic logic is_term(input logic [WIDTH-1:0] w);
    return (w & TERM_MASK) == TERM_VALUE;
  endfunction

  assign sel_data = input_in[int'(grant)*WIDTH +: WIDTH];
  assign sel_stb  = input_in_stb[grant];

  // Round-robin search: first requesting input after the last one served.
  always_comb begin
    pick     = last;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = GW'((int'(last) + k) % N);
      if (!pick_vld && input_in_stb[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state logic for the ARB -> ACK -> OUT handshake sequence.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    last_nxt   = last;
    lock_nxt   = lock;
    tcount_nxt = tcount;
    exc_nxt    = exception;
    out_nxt    = output_out;
    case (state)
      ARB: begin
        if (pick_vld) begin
          grant_nxt = pick;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (sel_stb) begin
          out_nxt    = sel_data;
          lock_nxt   = (LOCK_MODE != 0) && !is_term(sel_data);
          tcount_nxt = '0;
          state_nxt  = OUT;
        end else if (!lock) begin
          // Source withdrew without a lock: re-arbitrate, rotation untouched.
          state_nxt = ARB;
        end else if (tcount == TC_LAST) begin
          lock_nxt  = 1'b0;
          exc_nxt   = 1'b1;
          last_nxt  = grant;
          state_nxt = ARB;
        end else begin
          tcount_nxt = tcount + TW'(1);
        end
      end
      OUT: begin
        if (output_out_ack) begin
          if (lock) begin
            state_nxt = ACK;
          end else begin
            last_nxt  = grant;
            state_nxt = ARB;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // State and datapath registers; reset also discards any held word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB;
      grant      <= '0;
      last       <= LAST_RST;
      lock       <= 1'b0;
      tcount     <= '0;
      exception  <= 1'b0;
      output_out <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last       <= last_nxt;
      lock       <= lock_nxt;
      tcount     <= tcount_nxt;
      exception  <= exc_nxt;
      output_out <= out_nxt;
    end
  end

  // Handshake outputs decode registered state only; suppressed while in reset.
  always_comb begin
    input_in_ack   = '0;
    output_out_stb = rst && (state == OUT);
    if (rst && (state == ACK)) input_in_ack[grant] = 1'b1;
  end

endmodule

// File: tb/tb_stream_arbiter_n.sv
// Bench for stream_arbiter_n: a 4-input per-word instance and a 2-input
// packet-lock instance with a short timeout, driven by directed vectors.
module tb_stream_arbiter_n;

  logic         clk;
  logic         a_rst, b_rst;
  logic         a_exc, b_exc;
  logic [127:0] a_in;
  logic [3:0]   a_stb, a_ack;
  logic [31:0]  a_out;
  logic         a_ostb, a_oack;
  logic [63:0]  b_in;
  logic [1:0]   b_stb, b_ack;
  logic [31:0]  b_out;
  logic         b_ostb, b_oack;

  int n_chk, n_err;
  int a_cnt [4];

  typedef struct {
    logic [3:0]  stb;
    int          src;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [9];

  stream_arbiter_n #(.N(4), .WIDTH(32), .LOCK_MODE(0)) u_rr (
    .clk(clk), .rst(a_rst), .exception(a_exc),
    .input_in(a_in), .input_in_stb(a_stb), .input_in_ack(a_ack),
    .output_out(a_out), .output_out_stb(a_ostb), .output_out_ack(a_oack)
  );

  stream_arbiter_n #(.N(2), .WIDTH(32), .LOCK_MODE(1), .TIMEOUT(16)) u_lk (
    .clk(clk), .rst(b_rst), .exception(b_exc),
    .input_in(b_in), .input_in_stb(b_stb), .input_in_ack(b_ack),
    .output_out(b_out), .output_out_stb(b_ostb), .output_out_ack(b_oack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Input i of u_rr presents word 0xA0 + 0x10*i + (words already taken).
  task automatic drive_a();
    for (int i = 0; i < 4; i++)
      a_in[i*32 +: 32] = 32'hA0 + 32'(i) * 32'h10 + 32'(a_cnt[i]);
  endtask

  // Called one step after a rising edge with u_rr in ARB and the sink ready.
  task automatic xfer_a(input logic [3:0] stb, input int src,
                        input logic [31:0] exp, input string nm);
    a_stb = stb;
    drive_a();
    smp();
    chk({nm, "_arb_noack"}, 32'(a_ack), 32'd0);
    smp();
    chk({nm, "_ack"}, 32'(a_ack), 32'd1 << src);
    nxt();
    a_cnt[src]++;
    a_stb[src] = 1'b0;
    drive_a();
    smp();
    chk({nm, "_stb"}, 32'(a_ostb), 32'd1);
    chk({nm, "_data"}, a_out, exp);
    nxt();
  endtask

  initial begin
    tbl[0] = '{4'b0011, 0, 32'hA0};
    tbl[1] = '{4'b0010, 1, 32'hB0};
    tbl[2] = '{4'b0011, 0, 32'hA1};
    tbl[3] = '{4'b0010, 1, 32'hB1};
    tbl[4] = '{4'b1100, 2, 32'hC0};
    tbl[5] = '{4'b1001, 3, 32'hD0};
    tbl[6] = '{4'b0101, 0, 32'hA2};
    tbl[7] = '{4'b0100, 2, 32'hC1};
    tbl[8] = '{4'b0011, 0, 32'hA3};

    n_chk = 0;
    n_err = 0;
    a_rst = 1'b0;
    b_rst = 1'b0;
    a_stb = '0;
    b_stb = '0;
    b_in  = '0;
    a_oack = 1'b1;
    b_oack = 1'b1;
    for (int i = 0; i < 4; i++) a_cnt[i] = 0;
    drive_a();
    repeat (2) nxt();
    a_rst = 1'b1;
    b_rst = 1'b1;
    smp();
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_a_ostb", 32'(a_ostb), 32'd0);
    chk("rst_a_out", a_out, 32'd0);
    chk("rst_a_exc", 32'(a_exc), 32'd0);
    chk("rst_b_ostb", 32'(b_ostb), 32'd0);
    chk("rst_b_exc", 32'(b_exc), 32'd0);
    nxt();

    // Directed round-robin vectors
    for (int r = 0; r < 9; r++)
      xfer_a(tbl[r].stb, tbl[r].src, tbl[r].data, $sformatf("vec%0d", r));

    // Fresh start, then all four inputs request continuously
    a_stb = '0;
    a_rst = 1'b0;
    for (int i = 0; i < 4; i++) a_cnt[i] = 0;
    drive_a();
    nxt();
    a_rst = 1'b1;
    smp();
    nxt();
    for (int k = 0; k < 32; k++)
      xfer_a(4'b1111, k % 4, 32'hA0 + 32'(k % 4) * 32'h10 + 32'(k / 4),
             $sformatf("all%0d", k));

    // Sink stalls for 20 cycles
    a_oack = 1'b0;
    a_stb  = 4'b0011;
    drive_a();
    smp();
    smp();
    chk("stall_ack", 32'(a_ack), 32'd1);
    nxt();
    a_cnt[0]++;
    a_stb[0] = 1'b0;
    drive_a();
    for (int c = 0; c < 20; c++) begin
      smp();
      chk("stall_data", a_out, 32'hA8);
      chk("stall_stb", 32'(a_ostb), 32'd1);
      chk("stall_noack", 32'(a_ack), 32'd0);
    end
    nxt();
    a_oack = 1'b1;
    smp();
    chk("stall_release_stb", 32'(a_ostb), 32'd1);
    nxt();
    xfer_a(4'b0010, 1, 32'hB8, "resume");
    xfer_a(4'b0001, 0, 32'hA9, "pre_rst");

    // Reset while a word is held in OUT
    a_oack = 1'b0;
    a_stb  = 4'b0100;
    drive_a();
    smp();
    smp();
    chk("held_ack", 32'(a_ack), 32'd4);
    nxt();
    a_cnt[2]++;
    a_stb[2] = 1'b0;
    drive_a();
    smp();
    chk("held_data", a_out, 32'hC8);
    nxt();
    a_rst = 1'b0;
    smp();
    chk("rst_cycle_ack", 32'(a_ack), 32'd0);
    nxt();
    a_rst  = 1'b1;
    a_oack = 1'b1;
    smp();
    chk("post_rst_ack", 32'(a_ack), 32'd0);
    chk("post_rst_ostb", 32'(a_ostb), 32'd0);
    chk("post_rst_out", a_out, 32'd0);
    chk("post_rst_exc", 32'(a_exc), 32'd0);
    nxt();
    xfer_a(4'b0011, 0, 32'hAA, "post_rst_grant");

    // Packet lock: in0 sends 0x41,0x42,0x00 while in1 waits
    b_stb = 2'b11;
    b_in  = {32'h100, 32'h41};
    smp();
    smp();
    chk("lk_ack0", 32'(b_ack), 32'd1);
    nxt();
    b_in[31:0] = 32'h42;
    smp();
    chk("lk_out0", b_out, 32'h41);
    chk("lk_stb0", 32'(b_ostb), 32'd1);
    smp();
    chk("lk_ack1", 32'(b_ack), 32'd1);
    nxt();
    b_in[31:0] = 32'h00;
    smp();
    chk("lk_out1", b_out, 32'h42);
    smp();
    chk("lk_ack2", 32'(b_ack), 32'd1);
    nxt();
    b_stb[0] = 1'b0;
    smp();
    chk("lk_out2", b_out, 32'h00);
    smp();
    chk("lk_arb", 32'(b_ack), 32'd0);
    smp();
    chk("lk_ack_in1", 32'(b_ack), 32'd2);
    nxt();
    b_stb[1] = 1'b0;
    smp();
    chk("lk_out_in1", b_out, 32'h100);
    nxt();

    // Lock timeout: in0 sends 0x41 then goes quiet while in1 waits
    b_stb = 2'b01;
    b_in[31:0] = 32'h41;
    smp();
    smp();
    chk("to_ack0", 32'(b_ack), 32'd1);
    nxt();
    b_stb = 2'b10;
    b_in[63:32] = 32'h200;
    smp();
    chk("to_out0", b_out, 32'h41);
    for (int c = 0; c < 16; c++) begin
      smp();
      chk($sformatf("to_wait%0d_ack", c), 32'(b_ack), 32'd1);
      chk($sformatf("to_wait%0d_exc", c), 32'(b_exc), 32'd0);
    end
    smp();
    chk("to_exc_set", 32'(b_exc), 32'd1);
    chk("to_arb_ack", 32'(b_ack), 32'd0);
    smp();
    chk("to_ack_in1", 32'(b_ack), 32'd2);
    nxt();
    b_stb = 2'b00;
    smp();
    chk("to_out_in1", b_out, 32'h200);
    chk("to_exc_hold", 32'(b_exc), 32'd1);
    repeat (3) nxt();
    smp();
    chk("to_exc_sticky", 32'(b_exc), 32'd1);
    nxt();
    b_rst = 1'b0;
    nxt();
    b_rst = 1'b1;
    smp();
    chk("to_exc_cleared", 32'(b_exc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
